vga_timing: RTL and testbench

Free-running XGA (1024x768 @ 60 Hz, 65 MHz pixel clock) raster timing generator. It sits at the head of the `top_vga` pipeline and drives horizontal/vertical counters, blanking and sync strobes that every downstream draw stage consumes and that finally appear on the `hs`/`vs` pins. The total raster is 1344 x 806 pixel clocks. All outputs are registered and mutually aligned, so each stage receives a coherent (count, blank, sync) tuple in the same cycle.

---
 rtl/vga_timing_if.sv | 30 +++
 rtl/vga_timing.sv | 106 ++++++++++
 tb/tb_vga_timing.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// Raster timing bundle carried from vga_timing to the draw stages.
// frame_cnt is present only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_if #(
    parameter int CNT_W = 11
);
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             hblnk;
    logic             vsync;
    logic             vblnk;
    logic             frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0]      frame_cnt;

    modport master (
        output hcount, vcount, hsync, hblnk, vsync, vblnk, frame_start, frame_cnt
    );
    modport slave (
        input  hcount, vcount, hsync, hblnk, vsync, vblnk, frame_start, frame_cnt
    );
`else
    modport master (
        output hcount, vcount, hsync, hblnk, vsync, vblnk, frame_start
    );
    modport slave (
        input  hcount, vcount, hsync, hblnk, vsync, vblnk, frame_start
    );
`endif
endinterface

// File: rtl/vga_timing.sv
// Free-running raster timing generator (XGA defaults): counters, blanking, syncs, frame pulse.
// Optional frames-completed counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter int CNT_W    = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    vga_timing_if.master timing_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_BLNK_BEG = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_BLNK_BEG = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             hsync_q, hsync_d;
    logic             hblnk_q, hblnk_d;
    logic             vsync_q, vsync_d;
    logic             vblnk_q, vblnk_d;
    logic             frame_start_q, frame_start_d;

    // Flags decode the next-state counters so they land in the same register stage.
    always_comb begin
        hcount_d = hcount_q + CNT_ONE;
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : (vcount_q + CNT_ONE);
        end

        hblnk_d       = (hcount_d >= H_BLNK_BEG);
        hsync_d       = (hcount_d >= H_SYNC_BEG) && (hcount_d < H_SYNC_END);
        vblnk_d       = (vcount_d >= V_BLNK_BEG);
        vsync_d       = (vcount_d >= V_SYNC_BEG) && (vcount_d < V_SYNC_END);
        frame_start_d = (hcount_d == '0) && (vcount_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= 1'b0;
            hblnk_q       <= 1'b0;
            vsync_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            hblnk_q       <= hblnk_d;
            vsync_q       <= vsync_d;
            vblnk_q       <= vblnk_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign timing_o.hcount      = hcount_q;
    assign timing_o.vcount      = vcount_q;
    assign timing_o.hsync       = hsync_q;
    assign timing_o.hblnk       = hblnk_q;
    assign timing_o.vsync       = vsync_q;
    assign timing_o.vblnk       = vblnk_q;
    assign timing_o.frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Steps together with frame_start so the count and the pulse share a cycle.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign timing_o.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: an XGA instance and a small-raster instance share clk/rst_n;
// expected tuples are queued per (reset epoch, cycle) and checked by an independent monitor.
module tb_vga_timing;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    vga_timing_if #(.CNT_W(11)) big_if ();
    vga_timing_if #(.CNT_W(11)) small_if ();

    vga_timing u_big (
        .clk      (clk),
        .rst_n    (rst_n),
        .timing_o (big_if)
    );

    // Small raster: 16+2+3+4 = 25 pixels, 6+1+2+2 = 11 lines, 275-cycle frame.
    vga_timing #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (4),
        .V_ACTIVE (6),  .V_FP (1), .V_SYNC (2), .V_BP (2),
        .CNT_W    (11)
    ) u_small (
        .clk      (clk),
        .rst_n    (rst_n),
        .timing_o (small_if)
    );

    typedef struct {
        string tag;
        int    epoch;
        int    n;
        int    h;
        int    v;
        bit    hb;
        bit    hs;
        bit    vb;
        bit    vs;
        bit    fs;
        int    fc;     // -1: not checked
    } exp_t;

    exp_t q_big[$];
    exp_t q_small[$];

    int errors = 0;
    int checks = 0;

    // n: rising edges since reset release; epoch: number of reset assertions.
    int n     = 0;
    int epoch = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    always @(negedge rst_n) epoch <= epoch + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (epoch %0d cycle %0d)", name, act, exp, epoch, n);
        end
    endtask

    task automatic push(input bit dut, input string tag, input int ep, input int cyc,
                        input int h, input int v, input bit hb, input bit hs,
                        input bit vb, input bit vs, input bit fs, input int fc);
        exp_t e;
        e.tag = tag; e.epoch = ep; e.n = cyc; e.h = h; e.v = v;
        e.hb = hb; e.hs = hs; e.vb = vb; e.vs = vs; e.fs = fs; e.fc = fc;
        if (dut) q_small.push_back(e);
        else     q_big.push_back(e);
    endtask

    function automatic int q_size(input bit dut);
        return dut ? q_small.size() : q_big.size();
    endfunction

    function automatic exp_t q_head(input bit dut);
        return dut ? q_small[0] : q_big[0];
    endfunction

    task automatic q_drop(input bit dut);
        if (dut) void'(q_small.pop_front());
        else     void'(q_big.pop_front());
    endtask

    // Monitor: samples both DUTs 1 time unit after each falling clk edge and after reset assertion.
    int hs_big_cnt   = 0;
    int hs_small_cnt = 0;
    int vs_small_cnt = 0;
    int fs_small_cnt = 0;
    int fs_big_cnt   = 0;

    always begin
        @(negedge clk or negedge rst_n);
        #1;
        if (epoch == 1 && n >= 1 && n <= 1343 && big_if.hsync)   hs_big_cnt++;
        if (epoch == 1 && n >= 1 && n <= 24   && small_if.hsync) hs_small_cnt++;
        if (epoch == 1 && n >= 1 && n <= 274  && small_if.vsync) vs_small_cnt++;
        if (epoch == 1 && n >= 1 && small_if.frame_start)        fs_small_cnt++;
        if (big_if.frame_start)                                  fs_big_cnt++;

        for (int d = 0; d < 2; d++) begin
            bit   dsel;
            exp_t e;
            int   ah, av, ahb, ahs, avb, avs, afs, afc;
            dsel = (d == 1);
            ah  = dsel ? int'(small_if.hcount)      : int'(big_if.hcount);
            av  = dsel ? int'(small_if.vcount)      : int'(big_if.vcount);
            ahb = dsel ? int'(small_if.hblnk)       : int'(big_if.hblnk);
            ahs = dsel ? int'(small_if.hsync)       : int'(big_if.hsync);
            avb = dsel ? int'(small_if.vblnk)       : int'(big_if.vblnk);
            avs = dsel ? int'(small_if.vsync)       : int'(big_if.vsync);
            afs = dsel ? int'(small_if.frame_start) : int'(big_if.frame_start);
`ifdef VGA_TIMING_FRAME_CNT_EN
            afc = dsel ? int'(small_if.frame_cnt)   : int'(big_if.frame_cnt);
`else
            afc = -1;
`endif
            // Entries whose slot has already passed were never observed.
            while (q_size(dsel) > 0) begin
                e = q_head(dsel);
                if (e.epoch < epoch || (e.epoch == epoch && e.n < n)) begin
                    chk({e.tag, ".observed"}, 0, 1);
                    q_drop(dsel);
                end else begin
                    break;
                end
            end
            while (q_size(dsel) > 0) begin
                e = q_head(dsel);
                if (e.epoch != epoch || e.n != n) break;
                chk({e.tag, ".hcount"},      ah,  e.h);
                chk({e.tag, ".vcount"},      av,  e.v);
                chk({e.tag, ".hblnk"},       ahb, int'(e.hb));
                chk({e.tag, ".hsync"},       ahs, int'(e.hs));
                chk({e.tag, ".vblnk"},       avb, int'(e.vb));
                chk({e.tag, ".vsync"},       avs, int'(e.vs));
                chk({e.tag, ".frame_start"}, afs, int'(e.fs));
`ifdef VGA_TIMING_FRAME_CNT_EN
                if (e.fc >= 0) chk({e.tag, ".frame_cnt"}, afc, e.fc);
`else
                if (afc != -1) chk({e.tag, ".frame_cnt"}, afc, -1);
`endif
                q_drop(dsel);
            end
        end
    end

    initial begin
        // ---------------- XGA instance, hand-computed tuples ----------------
        //        tag            ep  n     h     v  hb hs vb vs fs fc
        push(0, "big_rst",       1,  0,    0,    0, 0, 0, 0, 0, 0, 0);
        push(0, "big_first",     1,  1,    1,    0, 0, 0, 0, 0, 0, 0);
        push(0, "big_h1023",     1,  1023, 1023, 0, 0, 0, 0, 0, 0, 0);
        push(0, "big_hblnk",     1,  1024, 1024, 0, 1, 0, 0, 0, 0, 0);
        push(0, "big_hs_pre",    1,  1047, 1047, 0, 1, 0, 0, 0, 0, 0);
        push(0, "big_hs_beg",    1,  1048, 1048, 0, 1, 1, 0, 0, 0, 0);
        push(0, "big_hs_end",    1,  1183, 1183, 0, 1, 1, 0, 0, 0, 0);
        push(0, "big_hs_post",   1,  1184, 1184, 0, 1, 0, 0, 0, 0, 0);
        push(0, "big_h_last",    1,  1343, 1343, 0, 1, 0, 0, 0, 0, 0);
        push(0, "big_h_wrap",    1,  1344, 0,    1, 0, 0, 0, 0, 0, 0);
        push(0, "big_h_next",    1,  1345, 1,    1, 0, 0, 0, 0, 0, 0);
        push(0, "big_pre_rst",   1,  1844, 500,  1, 0, 0, 0, 0, 0, 0);
        push(0, "big_mid_rst",   2,  0,    0,    0, 0, 0, 0, 0, 0, 0);
        push(0, "big_restart",   2,  1,    1,    0, 0, 0, 0, 0, 0, 0);
        push(0, "big_restart2",  2,  2,    2,    0, 0, 0, 0, 0, 0, 0);

        // ---------------- small instance: n = v*25 + h ----------------
        push(1, "sm_rst",        1,  0,    0,    0, 0, 0, 0, 0, 0, 0);
        push(1, "sm_h15",        1,  15,   15,   0, 0, 0, 0, 0, 0, 0);
        push(1, "sm_hblnk",      1,  16,   16,   0, 1, 0, 0, 0, 0, 0);
        push(1, "sm_hs_beg",     1,  18,   18,   0, 1, 1, 0, 0, 0, 0);
        push(1, "sm_hs_end",     1,  20,   20,   0, 1, 1, 0, 0, 0, 0);
        push(1, "sm_hs_post",    1,  21,   21,   0, 1, 0, 0, 0, 0, 0);
        push(1, "sm_h_last",     1,  24,   24,   0, 1, 0, 0, 0, 0, 0);
        push(1, "sm_h_wrap",     1,  25,   0,    1, 0, 0, 0, 0, 0, 0);
        push(1, "sm_v5_end",     1,  149,  24,   5, 1, 0, 0, 0, 0, 0);
        push(1, "sm_vblnk",      1,  150,  0,    6, 0, 0, 1, 0, 0, 0);
        push(1, "sm_vs_pre",     1,  174,  24,   6, 1, 0, 1, 0, 0, 0);
        push(1, "sm_vs_beg",     1,  175,  0,    7, 0, 0, 1, 1, 0, 0);
        push(1, "sm_vs_end",     1,  224,  24,   8, 1, 0, 1, 1, 0, 0);
        push(1, "sm_vs_post",    1,  225,  0,    9, 0, 0, 1, 0, 0, 0);
        push(1, "sm_f_last",     1,  274,  24,  10, 1, 0, 1, 0, 0, 0);
        push(1, "sm_frame1",     1,  275,  0,    0, 0, 0, 0, 0, 1, 1);
        push(1, "sm_frame1_nx",  1,  276,  1,    0, 0, 0, 0, 0, 0, 1);
        push(1, "sm_f2_last",    1,  549,  24,  10, 1, 0, 1, 0, 0, 1);
        push(1, "sm_frame2",     1,  550,  0,    0, 0, 0, 0, 0, 1, 2);
        push(1, "sm_frame3",     1,  825,  0,    0, 0, 0, 0, 0, 1, 3);
        push(1, "sm_fc_max",     1,  1099, 24,  10, 1, 0, 1, 0, 0, 65535);
        push(1, "sm_fc_wrap",    1,  1100, 0,    0, 0, 0, 0, 0, 1, 0);
        push(1, "sm_pre_rst",    1,  1844, 19,   7, 1, 1, 1, 1, 0, -1);
        push(1, "sm_mid_rst",    2,  0,    0,    0, 0, 0, 0, 0, 0, 0);
        push(1, "sm_restart",    2,  1,    1,    0, 0, 0, 0, 0, 0, 0);

        // Power-on reset: 4 cycles low, released between edges.
        #1 rst_n = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

`ifdef VGA_TIMING_FRAME_CNT_EN
        wait (n == 1050);
        #1 force u_small.frame_cnt_q = 16'hFFFF;
        #1 release u_small.frame_cnt_q;
`endif

        // Asynchronous reset mid-line, between clock edges.
        wait (n == 1844);
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        wait (n == 5);
        @(negedge clk);
        #2;

        chk("big_hsync_width",     hs_big_cnt,   136);
        chk("small_hsync_width",   hs_small_cnt, 3);
        chk("small_vsync_width",   vs_small_cnt, 50);
        chk("small_frame_pulses",  fs_small_cnt, 6);
        chk("big_frame_pulses",    fs_big_cnt,   0);
        chk("big_unchecked",       q_big.size(),   0);
        chk("small_unchecked",     q_small.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
